disp_vram_rdarb: RTL and testbench

//  Two-requester arbiter sharing the single AXI read port to VRAM.
//  S0 is the display VRAM read controller; S1 is a secondary reader (draw/blit engine).
//  S0 has fixed priority, with a starvation guard for S1.

---
 rtl/disp_vram_rdarb.sv | 117 +++++++++++
 tb/tb_disp_vram_rdarb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_vram_rdarb.sv
// disp_vram_rdarb: shares the single VRAM AXI read port between the display
// read controller (S0, fixed priority) and a secondary reader (S1).
// One burst is in flight at a time; R beats are routed back to the burst owner.
// S1 is forced in after FAIR_LIMIT consecutive S0 grants taken while it waited.
module disp_vram_rdarb #(
    parameter int DW         = 64,
    parameter int FAIR_LIMIT = 8
) (
    input  logic          ACLK,
    input  logic          ARST,
    input  logic [31:0]   S0_ARADDR,
    input  logic          S0_ARVALID,
    output logic          S0_ARREADY,
    output logic          S0_RVALID,
    output logic          S0_RLAST,
    input  logic          S0_RREADY,
    input  logic [31:0]   S1_ARADDR,
    input  logic          S1_ARVALID,
    output logic          S1_ARREADY,
    output logic          S1_RVALID,
    output logic          S1_RLAST,
    input  logic          S1_RREADY,
    output logic [DW-1:0] S_RDATA,
    output logic [31:0]   M_ARADDR,
    output logic          M_ARVALID,
    input  logic          M_ARREADY,
    input  logic [DW-1:0] M_RDATA,
    input  logic          M_RVALID,
    input  logic          M_RLAST,
    output logic          M_RREADY,
    output logic [1:0]    GRANT
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_ADDR = 3'b010,
        S_DATA = 3'b100
    } state_t;

    localparam logic [7:0] FAIR_LIM8 = 8'(FAIR_LIMIT);

    state_t     state;
    logic [7:0] streak;   // consecutive S0 grants taken while S1 was waiting
    logic       win0;
    logic       win1;
    logic       idle_act;
    logic       data_act;
    logic       own_rready;
    logic       r_done;

    // idle arbitration: S0 wins unless absent or S1 has waited out the fairness limit
    always_comb begin
        win1 = S1_ARVALID & (~S0_ARVALID | (streak == FAIR_LIM8));
        win0 = S0_ARVALID & ~win1;
    end

    // handshake gating and R-channel routing to the burst owner
    always_comb begin
        idle_act   = (state == S_IDLE) & ~ARST;
        data_act   = (state == S_DATA) & ~ARST;
        own_rready = (GRANT[0] & S0_RREADY) | (GRANT[1] & S1_RREADY);
        S0_ARREADY = idle_act & win0;
        S1_ARREADY = idle_act & win1;
        S0_RVALID  = data_act & GRANT[0] & M_RVALID;
        S0_RLAST   = data_act & GRANT[0] & M_RLAST;
        S1_RVALID  = data_act & GRANT[1] & M_RVALID;
        S1_RLAST   = data_act & GRANT[1] & M_RLAST;
        M_RREADY   = data_act & own_rready;
        r_done     = M_RVALID & M_RREADY & M_RLAST;
    end

    // data is broadcast; requesters qualify it with their own RVALID
    assign S_RDATA = M_RDATA;

    // burst FSM: grant and latch address, hold AR until accepted, drain R until RLAST
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state     <= S_IDLE;
            M_ARVALID <= 1'b0;
            M_ARADDR  <= '0;
            GRANT     <= '0;
            streak    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (win0 | win1) begin
                        state     <= S_ADDR;
                        M_ARVALID <= 1'b1;
                        M_ARADDR  <= win1 ? S1_ARADDR : S0_ARADDR;
                        GRANT     <= {win1, win0};
                        // only S0 grants that bypass a waiting S1 extend the streak
                        if (win1 | ~S1_ARVALID)
                            streak <= '0;
                        else if (streak != FAIR_LIM8)
                            streak <= streak + 8'd1;
                    end else begin
                        GRANT <= '0;
                    end
                end
                S_ADDR: begin
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_done) begin
                        state <= S_IDLE;
                        GRANT <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_vram_rdarb.sv
// Bench for disp_vram_rdarb: random and directed requester/AXI-slave traffic,
// a burst-level reference model checked every cycle, plus literal expectations.
module tb_disp_vram_rdarb;
    localparam int DW   = 64;
    localparam int FAIR = 8;

    logic          ACLK = 1'b0;
    logic          ARST;
    logic [31:0]   S0_ARADDR, S1_ARADDR, M_ARADDR;
    logic          S0_ARVALID, S0_ARREADY, S0_RVALID, S0_RLAST, S0_RREADY;
    logic          S1_ARVALID, S1_ARREADY, S1_RVALID, S1_RLAST, S1_RREADY;
    logic [DW-1:0] S_RDATA, M_RDATA;
    logic          M_ARVALID, M_ARREADY, M_RVALID, M_RLAST, M_RREADY;
    logic [1:0]    GRANT;

    disp_vram_rdarb #(.DW(DW), .FAIR_LIMIT(FAIR)) dut (
        .ACLK(ACLK), .ARST(ARST),
        .S0_ARADDR(S0_ARADDR), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
        .S0_RVALID(S0_RVALID), .S0_RLAST(S0_RLAST), .S0_RREADY(S0_RREADY),
        .S1_ARADDR(S1_ARADDR), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
        .S1_RVALID(S1_RVALID), .S1_RLAST(S1_RLAST), .S1_RREADY(S1_RREADY),
        .S_RDATA(S_RDATA),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RVALID(M_RVALID), .M_RLAST(M_RLAST), .M_RREADY(M_RREADY),
        .GRANT(GRANT)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0, failures = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    // stimulus policy (written by the sequencer at negedges, read by the driver)
    int n0 = 0, n1 = 0;
    int req0_pct = 100, req1_pct = 100, rr0_pct = 100, rr1_pct = 100, rv_pct = 100;
    int blen = 8, ar_delay = 0, ar_pct = 60, rst_req = 3, rnd_rst_pm = 0;
    bit fix0 = 0, rr1_tog = 0, t4_arm = 0;
    logic [31:0] addr0 = 32'h0;

    // AXI slave state
    bit burst_active = 0;
    int rem = 0, beat = 0, ar_wait = 0;

    // reference model: which requester owns the port, whether its address is still
    // outstanding, and how many S0 grants in a row have bypassed a waiting S1
    int m_owner = 0;          // 0 none, 1 S0, 2 S1
    bit m_addr = 0;
    int m_streak = 0;
    logic [31:0] m_addr_q = 32'h0;
    int glog[$];
    int cur_beats = 0;
    int arv_cyc = 0, beats0 = 0, beats1 = 0, rv0_cyc = 0, g01_cyc = 0;
    logic [31:0] last_ar = 32'h0;

    function automatic int pick(input bit v0, input bit v1, input int streak);
        if (v1 && (!v0 || streak == FAIR)) return 2;
        if (v0) return 1;
        return 0;
    endfunction

    // per-cycle compare against the model, then advance the model across the edge
    always @(negedge ACLK) begin : cmp
        int   win;
        logic e_ar0, e_ar1, e_rv0, e_rv1, e_rl0, e_rl1, e_mrr, own_rr;
        logic [1:0] e_grant;
        if (chk_en) begin
            win = 0;
            e_ar0 = 0; e_ar1 = 0; e_rv0 = 0; e_rv1 = 0; e_rl0 = 0; e_rl1 = 0; e_mrr = 0;
            e_grant = {m_owner == 2, m_owner == 1};
            own_rr = (m_owner == 1) ? S0_RREADY : S1_RREADY;
            if (!ARST) begin
                if (m_owner == 0) begin
                    win = pick(S0_ARVALID, S1_ARVALID, m_streak);
                    e_ar0 = (win == 1);
                    e_ar1 = (win == 2);
                end else if (!m_addr) begin
                    e_mrr = own_rr;
                    if (m_owner == 1) begin e_rv0 = M_RVALID; e_rl0 = M_RLAST; end
                    else begin e_rv1 = M_RVALID; e_rl1 = M_RLAST; end
                end
            end
            chk("grant", GRANT, e_grant);
            chk("m_arvalid", M_ARVALID, m_addr);
            chk("m_araddr", M_ARADDR, m_addr_q);
            chk("s0_arready", S0_ARREADY, e_ar0);
            chk("s1_arready", S1_ARREADY, e_ar1);
            chk("s0_rvalid", S0_RVALID, e_rv0);
            chk("s1_rvalid", S1_RVALID, e_rv1);
            chk("s0_rlast", S0_RLAST, e_rl0);
            chk("s1_rlast", S1_RLAST, e_rl1);
            chk("m_rready", M_RREADY, e_mrr);
            if (e_rv0 | e_rv1) chk("s_rdata", S_RDATA, M_RDATA);

            if (M_ARVALID) arv_cyc++;
            if (M_ARVALID && M_ARREADY) last_ar = M_ARADDR;
            if (S0_RVALID && S0_RREADY) beats0++;
            if (S1_RVALID && S1_RREADY) beats1++;
            if (S0_RVALID) rv0_cyc++;
            if (GRANT == 2'b01) g01_cyc++;

            if (ARST) begin
                m_owner = 0; m_addr = 0; m_streak = 0; m_addr_q = 32'h0;
            end else if (m_owner == 0) begin
                if (win != 0) begin
                    m_owner = win;
                    m_addr = 1;
                    m_addr_q = (win == 1) ? S0_ARADDR : S1_ARADDR;
                    glog.push_back(win);
                    cur_beats = 0;
                    if (win == 1 && S1_ARVALID) m_streak = (m_streak + 1 > FAIR) ? FAIR : m_streak + 1;
                    else m_streak = 0;
                end
            end else if (m_addr) begin
                if (M_ARREADY) m_addr = 0;
            end else if (M_RVALID && own_rr) begin
                cur_beats++;
                if (M_RLAST) m_owner = 0;
            end
        end
    end

    // driver: requesters hold ARVALID until accepted; the slave serves one burst per address
    initial begin : drv
        bit h_ar0, h_ar1, h_mar, h_mr, h_last;
        ARST = 1; S0_ARVALID = 0; S0_ARADDR = 0; S1_ARVALID = 0; S1_ARADDR = 0;
        S0_RREADY = 0; S1_RREADY = 0; M_ARREADY = 0; M_RDATA = 0; M_RVALID = 0; M_RLAST = 0;
        forever begin
            @(negedge ACLK);
            h_ar0 = S0_ARVALID & S0_ARREADY;
            h_ar1 = S1_ARVALID & S1_ARREADY;
            h_mar = M_ARVALID & M_ARREADY;
            h_mr  = M_RVALID & M_RREADY;
            h_last = h_mr & M_RLAST;
            @(posedge ACLK); #1;
            if (rst_req > 0 || (rnd_rst_pm > 0 && $urandom_range(0, 999) < rnd_rst_pm)) begin
                if (rst_req > 0) rst_req--;
                ARST = 1; S0_ARVALID = 0; S1_ARVALID = 0;
                M_ARREADY = 0; M_RVALID = 0; M_RLAST = 0;
                burst_active = 0; ar_wait = 0;
            end else begin
                ARST = 0;
                if (h_mr) begin beat++; if (h_last) burst_active = 0; end
                if (h_mar) begin
                    burst_active = 1; beat = 0; ar_wait = 0;
                    rem = (blen > 0) ? blen : $urandom_range(1, 8);
                end
                if (!(M_RVALID && !h_mr)) begin
                    M_RVALID = 0; M_RLAST = 0;
                    if (burst_active && pct(rv_pct)) begin
                        M_RVALID = 1;
                        M_RDATA = {$urandom, $urandom};
                        M_RLAST = (beat == rem - 1);
                        if (M_RLAST && t4_arm) begin
                            t4_arm = 0; S0_ARVALID = 1; S0_ARADDR = $urandom;
                        end
                    end
                end
                if (M_ARVALID) begin
                    if (ar_delay >= 0) begin M_ARREADY = (ar_wait >= ar_delay); ar_wait++; end
                    else M_ARREADY = pct(ar_pct);
                end else begin
                    M_ARREADY = (ar_delay < 0) ? pct(ar_pct) : 1'b0;
                end
                if (h_ar0) S0_ARVALID = 0;
                if (h_ar1) S1_ARVALID = 0;
                if (!S0_ARVALID && n0 > 0 && pct(req0_pct)) begin
                    S0_ARVALID = 1; S0_ARADDR = fix0 ? addr0 : $urandom; n0--;
                end
                if (!S1_ARVALID && n1 > 0 && pct(req1_pct)) begin
                    S1_ARVALID = 1; S1_ARADDR = $urandom; n1--;
                end
                S0_RREADY = pct(rr0_pct);
                S1_RREADY = rr1_tog ? ~S1_RREADY : pct(rr1_pct);
            end
        end
    end

    task automatic wait_quiet(input string nm, input int budget);
        int q = 0, t = 0;
        while (q < 3 && t < budget) begin
            @(negedge ACLK);
            t++;
            if (n0 == 0 && n1 == 0 && !S0_ARVALID && !S1_ARVALID && GRANT == 2'b00 && !burst_active && !ARST) q++;
            else q = 0;
        end
        chk({nm, "_quiet"}, q >= 3, 1);
    endtask

    task automatic chk_glog(input string nm, input int base, input int nexp, input int s1_at);
        chk({nm, "_ngrant"}, glog.size() - base, nexp);
        for (int i = 0; i < nexp; i++)
            chk($sformatf("%s_grant%0d", nm, i), (base + i < glog.size()) ? glog[base + i] : 0,
                (i == s1_at) ? 2 : 1);
    endtask

    initial begin : seq
        int b_g, b_arv, b_b0, b_b1, b_rv0, b_g01, t, stable, s1g;
        bit found;
        logic [31:0] a;

        repeat (2) @(negedge ACLK);
        chk_en = 1;
        chk("rst_grant", GRANT, 0);
        chk("rst_m_arvalid", M_ARVALID, 0);
        chk("rst_m_araddr", M_ARADDR, 0);
        chk("rst_m_rready", M_RREADY, 0);
        wait_quiet("rst", 20);

        // T1: single S0 burst, AR accepted on the 4th cycle, 8 beats
        b_g = glog.size(); b_arv = arv_cyc; b_b0 = beats0; b_g01 = g01_cyc;
        fix0 = 1; addr0 = 32'h1000_0000; ar_delay = 3; blen = 8; n0 = 1;
        wait_quiet("t1", 200);
        chk_glog("t1", b_g, 1, -1);
        chk("t1_arvalid_cycles", arv_cyc - b_arv, 4);
        chk("t1_addr", last_ar, 32'h1000_0000);
        chk("t1_beats", beats0 - b_b0, 8);
        chk("t1_grant01_seen", (g01_cyc - b_g01) > 0, 1);
        chk("t1_grant_idle", GRANT, 0);
        fix0 = 0; ar_delay = 0;

        // T2: both requesting, S0 continuously: 8 S0, then S1, then S0
        b_g = glog.size(); n0 = 10; n1 = 1;
        wait_quiet("t2", 1500);
        chk_glog("t2", b_g, 11, 8);

        // T3: S1 burst with RREADY toggling
        b_g = glog.size(); b_b1 = beats1; b_rv0 = rv0_cyc;
        rr1_tog = 1; n1 = 1;
        wait_quiet("t3", 300);
        chk("t3_owner", glog.size() > b_g ? glog[b_g] : 0, 2);
        chk("t3_beats", beats1 - b_b1, 8);
        chk("t3_s0_rvalid_cycles", rv0_cyc - b_rv0, 0);
        rr1_tog = 0;

        // T4: S0 request raised in the cycle S1's RLAST completes
        b_g = glog.size(); blen = 2; t4_arm = 1; n1 = 1;
        t = 0; found = 0;
        while (!found && t < 100) begin
            @(negedge ACLK); t++;
            if (GRANT == 2'b10 && M_RVALID && M_RREADY && M_RLAST) found = 1;
        end
        chk("t4_rlast_seen", found, 1);
        chk("t4_s0_arvalid", S0_ARVALID, 1);
        chk("t4_s0_arready_early", S0_ARREADY, 0);
        @(negedge ACLK);
        chk("t4_s0_arready_next", S0_ARREADY, 1);
        chk("t4_grant_idle", GRANT, 0);
        wait_quiet("t4", 200);
        chk("t4_first", glog.size() > b_g ? glog[b_g] : 0, 2);
        chk("t4_second", glog.size() > b_g + 1 ? glog[b_g + 1] : 0, 1);

        // T5: reset at beat 3 of the third S0 burst while S1 waits; streak must restart
        b_g = glog.size(); blen = 8; n0 = 3; n1 = 1;
        t = 0;
        while (!(glog.size() >= b_g + 3 && m_owner == 1 && cur_beats >= 3) && t < 500) begin
            @(negedge ACLK); t++;
        end
        chk("t5_reach_beat3", t < 500, 1);
        rst_req = 1;
        @(negedge ACLK);
        chk("t5_in_rst", ARST, 1);
        chk("t5_rst_s0_rvalid", S0_RVALID, 0);
        @(negedge ACLK);
        chk("t5_grant", GRANT, 0);
        chk("t5_m_arvalid", M_ARVALID, 0);
        chk("t5_m_rready", M_RREADY, 0);
        wait_quiet("t5_rst", 50);
        b_g = glog.size(); n0 = 9; n1 = 1;
        wait_quiet("t5", 1500);
        chk_glog("t5", b_g, 10, 8);

        // T6: AR stalled for 20 cycles with S1 also waiting
        b_g = glog.size(); ar_delay = 20; blen = 2; n0 = 1; n1 = 1;
        t = 0;
        while (M_ARVALID !== 1'b1 && t < 50) begin @(negedge ACLK); t++; end
        a = M_ARADDR; stable = 0;
        repeat (20) begin
            if (M_ARVALID && !M_ARREADY && M_ARADDR == a && S1_ARVALID && !S0_ARREADY && !S1_ARREADY)
                stable++;
            @(negedge ACLK);
        end
        chk("t6_hold_cycles", stable, 20);
        chk("t6_accept", M_ARREADY & M_ARVALID, 1);
        ar_delay = 0;
        wait_quiet("t6", 300);
        chk_glog("t6", b_g, 2, 1);

        // random traffic with occasional resets
        b_g = glog.size();
        ar_delay = -1; blen = 0; req0_pct = 50; req1_pct = 40;
        rr0_pct = 70; rr1_pct = 60; rv_pct = 70; rnd_rst_pm = 3;
        n0 = 100000; n1 = 100000;
        repeat (4000) @(negedge ACLK);
        n0 = 0; n1 = 0; rnd_rst_pm = 0; ar_delay = 0; rv_pct = 100; rr0_pct = 100; rr1_pct = 100;
        wait_quiet("rand", 1000);
        s1g = 0;
        for (int i = b_g; i < glog.size(); i++) if (glog[i] == 2) s1g++;
        chk("rand_s1_granted", s1g > 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
